// File: rtl/ospfb_frame_ctrl.sv
// ospfb_frame_ctrl: per-branch load/recirculate sequencing and rotation-phase tracking for an oversampled PFB
module ospfb_frame_ctrl #(
  parameter int FFT_LEN = 64,
  parameter int DEC_FAC = 48,
  parameter int WIDTH = 16,
  parameter int STALLW = 16,
  localparam int BW = $clog2(FFT_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              dp_en,
  output logic              dp_load,
  output logic [WIDTH-1:0]  dp_din,
  output logic [BW-1:0]     dp_branch,
  output logic              dp_sof,
  output logic              dp_eof,
  output logic [BW-1:0]     rot_phase,
  output logic              busy,
  output logic [STALLW-1:0] stall_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [BW-1:0] BR_MAX = BW'(FFT_LEN - 1);
  localparam logic [BW:0] D_EXT = (BW+1)'(DEC_FAC);
  localparam logic [BW:0] M_EXT = (BW+1)'(FFT_LEN);
  state_t state_q, state_d;
  logic [BW-1:0] br_q, br_d, phase_q, phase_d;
  logic go, need, adv, last;
  logic [BW:0] psum;
  always_comb begin
    need = {1'b0, br_q} < D_EXT;
    last = br_q == '0;
    go = state_q == DRAIN || (state_q == RUN && (run || br_q != BR_MAX));
    adv = go && (!need || s_valid);
    s_ready = go && need;
    psum = {1'b0, phase_q} + D_EXT;
    state_d = state_q;
    br_d = adv ? (last ? BR_MAX : br_q - 1'b1) : br_q;
    phase_d = adv && last ? (psum >= M_EXT ? BW'(psum - M_EXT) : BW'(psum)) : phase_q;
    case (state_q)
      IDLE: if (run) begin
        state_d = RUN;
        br_d = BR_MAX;
        phase_d = '0;
      end
      RUN: if (!run) state_d = (!go || (adv && last)) ? IDLE : DRAIN;
      DRAIN: if (adv && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      br_q <= BR_MAX;
      phase_q <= '0;
      dp_en <= 1'b0;
      dp_load <= 1'b0;
      dp_din <= '0;
      dp_branch <= BR_MAX;
      dp_sof <= 1'b0;
      dp_eof <= 1'b0;
      rot_phase <= '0;
      busy <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      br_q <= br_d;
      phase_q <= phase_d;
      dp_en <= adv;
      dp_load <= adv && need;
      dp_din <= adv && need ? s_data : '0;
      dp_sof <= adv && br_q == BR_MAX;
      dp_eof <= adv && last;
      if (adv) begin
        dp_branch <= br_q;
        rot_phase <= phase_q;
      end
      busy <= state_d != IDLE;
      if (go && need && !s_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: doc/ospfb_frame_ctrl.md
Name: ospfb_frame_ctrl

Overview:
Sequencing controller for the oversampled PFB front end.
- Walks the M polyphase branches once per frame and decides, each branch cycle, whether the DelayBuf/PE chain shifts in a new input sample (load) or recirculates (overlap).
- Tracks the per-frame circular-shift phase that the downstream FFT reorder needs.
- Sits between the input AXIS-style sample stream and the DelayBuf/PE enable, din and control inputs.

Parameters:
FFT_LEN, 64, M: number of polyphase branches; power of two, at least 4.
DEC_FAC, 48, D: new samples consumed per frame; 1 <= D <= FFT_LEN.
WIDTH, 16, sample width.
STALLW, 16, width of saturating stall counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk.
run  in  1  level; 1 = process frames, 0 = finish current frame then idle.
s_data  in  WIDTH  input sample.
s_valid  in  1  input sample valid.
s_ready  out  1  combinational; controller accepts s_data this cycle.
dp_en  out  1  registered; datapath (DelayBuf/PE) advance strobe.
dp_load  out  1  registered; 1 = dp_din carries a new sample, 0 = recirculate cycle.
dp_din  out  WIDTH  registered sample to datapath; 0 when dp_load = 0.
dp_branch  out  clog2(FFT_LEN)  registered branch index of this dp_en cycle.
dp_sof  out  1  registered; first branch of frame (branch M-1) on this dp_en.
dp_eof  out  1  registered; last branch of frame (branch 0) on this dp_en.
rot_phase  out  clog2(FFT_LEN)  registered circular-shift phase of the current frame.
busy  out  1  registered; state != IDLE.
stall_cnt  out  STALLW  registered; saturating count of cycles stalled waiting for s_valid.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; br=M-1; phase=0; all outputs 0 except dp_branch=M-1. stall_cnt=0.
- Internal branch counter br counts M-1 down to 0. need = (br < D).
- States and transitions:
  - IDLE: s_ready=0, no advance. run=1 -> RUN with br=M-1, phase=0, stall_cnt kept.
  - RUN: adv = !need || s_valid. s_ready = need.
    - On adv: br decrements. At br=0 it wraps to M-1 and phase <= (phase + D) mod M (implemented as compare/subtract, no divider).
    - run=0 sampled with br != M-1, or mid-stall -> DRAIN.
    - run=0 at a frame boundary (br=M-1, no advance yet) -> IDLE.
  - DRAIN: same advance rules as RUN. On adv with br=0 -> IDLE: br=M-1, phase still updated. run re-asserted in DRAIN is ignored until IDLE is reached.
- Registered outputs, 1-cycle latency from adv:
  - dp_en=adv
  - dp_load=adv&&need
  - dp_din=s_data if load, else 0
  - dp_branch=br
  - dp_sof=adv&&(br==M-1)
  - dp_eof=adv&&(br==0)
  - rot_phase=phase before update; all branches of one frame carry the same value.
- When dp_en=0, dp_load/dp_sof/dp_eof are 0, and dp_branch/rot_phase hold their values.
- Stall: RUN/DRAIN with need && !s_valid -> dp_en=0, br holds, stall_cnt += 1, saturating at 2^STALLW-1.
- D=M: every cycle is a load; phase stays 0.
- Reset asserted mid-frame: immediate return to reset values; partial frame discarded.
- Phase period: M/gcd(M,D) frames.

Test Plan:
- M=8, D=6, s_valid=1, run=1 for 3 frames -> dp_en high continuously after 1-cycle latency. Per frame dp_load pattern over branches 7..0 = 0,0,1,1,1,1,1,1. rot_phase 0,6,4. 18 samples consumed.
- M=8, D=6, run held 5 frames -> rot_phase sequence 0,6,4,2,0; dp_sof/dp_eof one-cycle pulses at branch 7 and branch 0.
- s_valid low 3 cycles at branch 4 -> dp_en low 3 cycles, br holds 4, stall_cnt +3. s_ready stays high. dp_din values in order without loss or duplication.
- s_valid low during branches 7 and 6 -> no stall, because those are recirculate cycles. stall_cnt unchanged. s_ready=0 on those cycles.
- run dropped at branch 5 -> frame completes through branch 0, then busy=0 and s_ready=0. run re-raised -> next frame starts at branch 7 with rot_phase=0.
- rst_n pulsed low at branch 3 -> outputs zero immediately, dp_branch=7. Restart gives rot_phase=0. Also D=M=8 -> dp_load always 1 and rot_phase constant 0.
